// File: rtl/space_inv_pkg.sv
// space_inv_pkg: shared scheduler types, slot constants and the round-robin step helper
// Contents: sched_state_t, NUM_SLOTS, PLAYER_SLOT, DIR_UP/DIR_DOWN, SCREEN_Y_MAX, rr_slot()
package space_inv_pkg;

   typedef enum logic [2:0] {
      WAIT_ST,
      COOL_ST,
      ARB_ST,
      LAUNCH_P_ST,
      LAUNCH_A_ST
   } sched_state_t;

   localparam int   NUM_SLOTS    = 4;
   localparam int   PLAYER_SLOT  = 0;
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam int   SCREEN_Y_MAX = 479;

   // Alien slot visited 'step' places after 'last', cycling through 1..3 only.
   function automatic logic [1:0] rr_slot(input logic [1:0] last, input int step);
      return 2'((int'(last) + step - 1) % 3 + 1);
   endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// rr_slot_picker: combinational round-robin choice of a free alien slot (1..3)
// Ports: free_i  - per-slot free mask (bit 0, the player slot, is never chosen)
//        last_i  - alien slot used by the previous alien launch
//        found_o - some alien slot is free
//        slot_o  - first free alien slot after last_i, wrapping 3 -> 1
module rr_slot_picker
   import space_inv_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] free_i,
   input  logic [1:0]           last_i,
   output logic                 found_o,
   output logic [1:0]           slot_o
);

   // Walk the candidates farthest-first so the nearest free slot overwrites the others.
   always_comb begin
      found_o = 1'b0;
      slot_o  = last_i;
      for (int s = 3; s >= 1; s--) begin
         if (free_i[rr_slot(last_i, s)]) begin
            found_o = 1'b1;
            slot_o  = rr_slot(last_i, s);
         end
      end
   end

endmodule

// File: rtl/projectile_scheduler.sv
// projectile_scheduler: per-frame arbitration and launch of player/alien projectiles over 4 slots
// Ports: clk, reset (sync, active-high); startOfFrame/enable frame pacing;
//        player_fire, ship_x/ship_y player request; alien_fire_req, alien_x/alien_y, alien_fire_ack
//        alien request/grant; slot_done slot release; launch, launch_x/launch_y/launch_dir launch
//        outputs; slot_busy occupancy; player_ready player may fire now.
module projectile_scheduler
   import space_inv_pkg::*;
#(
   parameter int PLAYER_COOLDOWN = 8,
   parameter int ALIEN_COOLDOWN  = 20,
   parameter int PLAYER_Y_OFFSET = 33,
   parameter int ALIEN_Y_OFFSET  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 startOfFrame,
   input  logic                 enable,
   input  logic                 player_fire,
   input  logic [10:0]          ship_x,
   input  logic [10:0]          ship_y,
   input  logic                 alien_fire_req,
   input  logic [10:0]          alien_x,
   input  logic [10:0]          alien_y,
   output logic                 alien_fire_ack,
   input  logic [NUM_SLOTS-1:0] slot_done,
   output logic [NUM_SLOTS-1:0] launch,
   output logic [10:0]          launch_x,
   output logic [10:0]          launch_y,
   output logic                 launch_dir,
   output logic [NUM_SLOTS-1:0] slot_busy,
   output logic                 player_ready
);

   sched_state_t         state_q, state_d;
   logic                 fire_s_q, fire_h_q, fire_edge;
   logic                 pend_q, pend_d;
   logic                 pgrant_q, pgrant_d, agrant_q, agrant_d;
   logic [1:0]           aslot_q, aslot_d, last_q, last_d;
   logic [10:0]          ax_q, ax_d, ay_q, ay_d;
   logic [7:0]           pcool_q, pcool_d, acool_q, acool_d;
   logic [NUM_SLOTS-1:0] launch_q, launch_d, busy_q, busy_d;
   logic [10:0]          lx_q, lx_d, ly_q, ly_d;
   logic                 ldir_q, ldir_d;
   logic                 found, a_ok;
   logic [1:0]           pick;
   logic [11:0]          py, ay_sum;

   rr_slot_picker u_pick (
      .free_i  (~busy_q),
      .last_i  (last_q),
      .found_o (found),
      .slot_o  (pick)
   );

   assign fire_edge      = fire_s_q & ~fire_h_q;
   // 12-bit results: bit 11 of py flags underflow, ay_sum may exceed the screen.
   assign py             = {1'b0, ship_y} - 12'(PLAYER_Y_OFFSET);
   assign ay_sum         = {1'b0, ay_q} + 12'(ALIEN_Y_OFFSET);
   assign a_ok           = alien_fire_req && found && acool_q == '0;
   assign alien_fire_ack = state_q == ARB_ST && a_ok;
   assign player_ready   = !busy_q[PLAYER_SLOT] && pcool_q == '0;
   assign launch         = launch_q;
   assign launch_x       = lx_q;
   assign launch_y       = ly_q;
   assign launch_dir     = ldir_q;
   assign slot_busy      = busy_q;

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q | fire_edge;
      pgrant_d = pgrant_q;
      agrant_d = agrant_q;
      aslot_d  = aslot_q;
      last_d   = last_q;
      ax_d     = ax_q;
      ay_d     = ay_q;
      pcool_d  = pcool_q;
      acool_d  = acool_q;
      launch_d = '0;
      busy_d   = busy_q & ~slot_done;
      lx_d     = lx_q;
      ly_d     = ly_q;
      ldir_d   = ldir_q;
      case (state_q)
         WAIT_ST: state_d = startOfFrame && enable ? COOL_ST : WAIT_ST;
         COOL_ST: begin
            pcool_d = pcool_q == '0 ? '0 : pcool_q - 8'd1;
            acool_d = acool_q == '0 ? '0 : acool_q - 8'd1;
            state_d = ARB_ST;
         end
         ARB_ST: begin
            pgrant_d = pend_q && !busy_q[PLAYER_SLOT] && pcool_q == '0;
            agrant_d = a_ok;
            aslot_d  = pick;
            ax_d     = a_ok ? alien_x : ax_q;
            ay_d     = a_ok ? alien_y : ay_q;
            state_d  = LAUNCH_P_ST;
         end
         LAUNCH_P_ST: begin
            if (pgrant_q) begin
               launch_d[PLAYER_SLOT] = 1'b1;
               busy_d[PLAYER_SLOT]   = 1'b1;
               lx_d    = ship_x;
               ly_d    = py[11] ? '0 : py[10:0];
               ldir_d  = DIR_UP;
               pend_d  = 1'b0;
               pcool_d = 8'(PLAYER_COOLDOWN);
            end
            state_d = LAUNCH_A_ST;
         end
         LAUNCH_A_ST: begin
            if (agrant_q) begin
               launch_d[aslot_q] = 1'b1;
               busy_d[aslot_q]   = 1'b1;
               lx_d    = ax_q;
               ly_d    = ay_sum > 12'(SCREEN_Y_MAX) ? 11'(SCREEN_Y_MAX) : ay_sum[10:0];
               ldir_d  = DIR_DOWN;
               last_d  = aslot_q;
               acool_d = 8'(ALIEN_COOLDOWN);
            end
            state_d = WAIT_ST;
         end
         default: state_d = WAIT_ST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= WAIT_ST;
         fire_s_q <= 1'b1;
         fire_h_q <= 1'b1;
         pend_q   <= 1'b0;
         pgrant_q <= 1'b0;
         agrant_q <= 1'b0;
         aslot_q  <= 2'd1;
         last_q   <= 2'd3;
         ax_q     <= '0;
         ay_q     <= '0;
         pcool_q  <= '0;
         acool_q  <= '0;
         launch_q <= '0;
         busy_q   <= '0;
         lx_q     <= '0;
         ly_q     <= '0;
         ldir_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         fire_s_q <= player_fire;
         fire_h_q <= fire_s_q;
         pend_q   <= pend_d;
         pgrant_q <= pgrant_d;
         agrant_q <= agrant_d;
         aslot_q  <= aslot_d;
         last_q   <= last_d;
         ax_q     <= ax_d;
         ay_q     <= ay_d;
         pcool_q  <= pcool_d;
         acool_q  <= acool_d;
         launch_q <= launch_d;
         busy_q   <= busy_d;
         lx_q     <= lx_d;
         ly_q     <= ly_d;
         ldir_q   <= ldir_d;
      end
   end

endmodule

// File: tb/tb_projectile_scheduler.sv
// tb_projectile_scheduler: directed self-checking bench for projectile_scheduler
module tb_projectile_scheduler;

   logic        clk = 1'b0;
   logic        reset, startOfFrame, enable, player_fire, alien_fire_req, alien_fire_ack;
   logic [10:0] ship_x, ship_y, alien_x, alien_y, launch_x, launch_y;
   logic [3:0]  slot_done, launch, slot_busy;
   logic        launch_dir, player_ready;

   int          tests = 0;
   int          fails = 0;
   logic        ack_seen, p_d, a_d;
   logic [3:0]  p_l, a_l;
   logic [10:0] p_x, p_y, a_x, a_y;

   always #5 clk = ~clk;

   projectile_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .enable         (enable),
      .player_fire    (player_fire),
      .ship_x         (ship_x),
      .ship_y         (ship_y),
      .alien_fire_req (alien_fire_req),
      .alien_x        (alien_x),
      .alien_y        (alien_y),
      .alien_fire_ack (alien_fire_ack),
      .slot_done      (slot_done),
      .launch         (launch),
      .launch_x       (launch_x),
      .launch_y       (launch_y),
      .launch_dir     (launch_dir),
      .slot_busy      (slot_busy),
      .player_ready   (player_ready)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // One frame: SOF, observe ack in ARB, player launch 4 cycles later, alien launch 5 cycles later.
   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      ack_seen = alien_fire_ack;
      tick();
      tick();
      p_l = launch; p_x = launch_x; p_y = launch_y; p_d = launch_dir;
      tick();
      a_l = launch; a_x = launch_x; a_y = launch_y; a_d = launch_dir;
   endtask

   task automatic press();
      player_fire = 1'b1;
      repeat (3) tick();
      player_fire = 1'b0;
      repeat (2) tick();
   endtask

   task automatic clear(input logic [3:0] m);
      slot_done = m;
      tick();
      slot_done = '0;
   endtask

   task automatic test_reset();
      player_fire = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      tests++; if (launch !== 4'b0000) begin fails++; $display("FAIL reset_launch got %b want 0000", launch); end
      tests++; if (slot_busy !== 4'b0000) begin fails++; $display("FAIL reset_busy got %b want 0000", slot_busy); end
      tests++; if ({launch_x, launch_y, launch_dir} !== 23'd0) begin fails++; $display("FAIL reset_coords got %0d,%0d,%b want 0,0,0", launch_x, launch_y, launch_dir); end
      tests++; if (alien_fire_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", alien_fire_ack); end
      tests++; if (player_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", player_ready); end
      frame();
      tests++; if (p_l !== 4'b0000) begin fails++; $display("FAIL held_fire_no_launch got %b want 0000", p_l); end
      player_fire = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_player();
      int bad;
      ship_x = 11'd100; ship_y = 11'd200;
      press();
      frame();
      tests++; if (p_l !== 4'b0001) begin fails++; $display("FAIL p_launch got %b want 0001", p_l); end
      tests++; if (p_x !== 11'd100 || p_y !== 11'd167 || p_d !== 1'b0) begin fails++; $display("FAIL p_coords got %0d,%0d,%b want 100,167,0", p_x, p_y, p_d); end
      tests++; if (a_l !== 4'b0000 || a_x !== 11'd100 || a_y !== 11'd167) begin fails++; $display("FAIL p_hold got %b %0d,%0d want 0000 100,167", a_l, a_x, a_y); end
      tests++; if (slot_busy !== 4'b0001 || player_ready !== 1'b0) begin fails++; $display("FAIL p_busy got %b ready %b want 0001 ready 0", slot_busy, player_ready); end
      press();
      clear(4'b0001);
      tests++; if (slot_busy !== 4'b0000) begin fails++; $display("FAIL p_done got %b want 0000", slot_busy); end
      bad = 0;
      repeat (7) begin frame(); if (p_l !== 4'b0000) bad++; end
      tests++; if (bad != 0) begin fails++; $display("FAIL p_cooldown_block got %0d launches want 0", bad); end
      frame();
      tests++; if (p_l !== 4'b0001) begin fails++; $display("FAIL p_after_cooldown got %b want 0001", p_l); end
      clear(4'b0001);
   endtask

   task automatic test_underflow();
      int bad;
      ship_y = 11'd20;
      press();
      bad = 0;
      repeat (7) begin frame(); if (p_l !== 4'b0000) bad++; end
      frame();
      tests++; if (bad != 0 || p_l !== 4'b0001 || p_y !== 11'd0) begin fails++; $display("FAIL p_underflow got early %0d launch %b y %0d want 0 0001 0", bad, p_l, p_y); end
      clear(4'b0001);
   endtask

   task automatic test_alien();
      int bad;
      alien_fire_req = 1'b1; alien_x = 11'd300; alien_y = 11'd100;
      frame();
      tests++; if (ack_seen !== 1'b1) begin fails++; $display("FAIL a_ack got %b want 1", ack_seen); end
      tests++; if (a_l !== 4'b0010 || a_x !== 11'd300 || a_y !== 11'd116 || a_d !== 1'b1) begin fails++; $display("FAIL a_first got %b %0d,%0d,%b want 0010 300,116,1", a_l, a_x, a_y, a_d); end
      bad = 0;
      repeat (19) begin frame(); if (ack_seen !== 1'b0 || a_l !== 4'b0000) bad++; end
      tests++; if (bad != 0) begin fails++; $display("FAIL a_cooldown_block got %0d grants want 0", bad); end
      frame();
      tests++; if (a_l !== 4'b0100) begin fails++; $display("FAIL a_second got %b want 0100", a_l); end
      repeat (19) frame();
      frame();
      tests++; if (a_l !== 4'b1000 || slot_busy !== 4'b1110) begin fails++; $display("FAIL a_third got %b busy %b want 1000 busy 1110", a_l, slot_busy); end
      clear(4'b0100);
      tests++; if (slot_busy !== 4'b1010) begin fails++; $display("FAIL a_done got %b want 1010", slot_busy); end
      repeat (19) frame();
      frame();
      tests++; if (a_l !== 4'b0100) begin fails++; $display("FAIL a_reuse got %b want 0100", a_l); end
   endtask

   task automatic test_overflow();
      int bad;
      clear(4'b1110);
      alien_y = 11'd470;
      bad = 0;
      repeat (19) begin frame(); if (a_l !== 4'b0000) bad++; end
      frame();
      tests++; if (bad != 0 || a_l !== 4'b1000 || a_y !== 11'd479 || a_d !== 1'b1) begin fails++; $display("FAIL a_overflow got early %0d %b y %0d dir %b want 0 1000 479 1", bad, a_l, a_y, a_d); end
   endtask

   task automatic test_back_to_back();
      alien_fire_req = 1'b0;
      clear(4'b1000);
      repeat (20) frame();
      alien_fire_req = 1'b1; alien_y = 11'd50; ship_x = 11'd64; ship_y = 11'd300;
      press();
      frame();
      tests++; if (p_l !== 4'b0001 || p_x !== 11'd64 || p_y !== 11'd267 || p_d !== 1'b0) begin fails++; $display("FAIL both_player got %b %0d,%0d,%b want 0001 64,267,0", p_l, p_x, p_y, p_d); end
      tests++; if (a_l !== 4'b0010 || a_x !== 11'd300 || a_y !== 11'd66 || a_d !== 1'b1) begin fails++; $display("FAIL both_alien got %b %0d,%0d,%b want 0010 300,66,1", a_l, a_x, a_y, a_d); end
      alien_fire_req = 1'b0;
   endtask

   task automatic test_pause();
      int bad;
      enable = 1'b0;
      clear(4'b0011);
      tests++; if (slot_busy !== 4'b0000) begin fails++; $display("FAIL pause_done got %b want 0000", slot_busy); end
      press();
      bad = 0;
      repeat (5) begin frame(); if (p_l !== 4'b0000) bad++; end
      tests++; if (bad != 0 || player_ready !== 1'b0) begin fails++; $display("FAIL pause_hold got %0d launches ready %b want 0 ready 0", bad, player_ready); end
      enable = 1'b1;
      bad = 0;
      repeat (7) begin frame(); if (p_l !== 4'b0000) bad++; end
      frame();
      tests++; if (bad != 0 || p_l !== 4'b0001) begin fails++; $display("FAIL pause_frozen_cool got early %0d launch %b want 0 0001", bad, p_l); end
      clear(4'b0001);
      repeat (8) frame();
      tests++; if (player_ready !== 1'b1) begin fails++; $display("FAIL ready_again got %b want 1", player_ready); end
      enable = 1'b0;
      press();
      bad = 0;
      repeat (5) begin frame(); if (p_l !== 4'b0000) bad++; end
      enable = 1'b1;
      frame();
      tests++; if (bad != 0 || p_l !== 4'b0001) begin fails++; $display("FAIL resume_launch got early %0d launch %b want 0 0001", bad, p_l); end
      clear(4'b0001);
   endtask

   task automatic test_reset_abort();
      repeat (8) frame();
      press();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tests++; if (launch !== 4'b0000 || slot_busy !== 4'b0000) begin fails++; $display("FAIL abort_launch got %b busy %b want 0000 0000", launch, slot_busy); end
      reset = 1'b0;
      tick();
      tests++; if (launch !== 4'b0000) begin fails++; $display("FAIL abort_after got %b want 0000", launch); end
      frame();
      tests++; if (p_l !== 4'b0000) begin fails++; $display("FAIL abort_pending got %b want 0000", p_l); end
   endtask

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; enable = 1'b1; player_fire = 1'b0;
      ship_x = '0; ship_y = '0; alien_fire_req = 1'b0; alien_x = '0; alien_y = '0; slot_done = '0;
      tick();
      test_reset();
      test_player();
      test_underflow();
      test_alien();
      test_overflow();
      test_back_to_back();
      test_pause();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
